muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage. It sits beside the single-cycle ALU and handles the eight M-extension operations, which are too costly to do combinationally. Operands are latched on a start pulse and processed one bit per cycle. The unit signals busy for the pipeline stall logic and pulses done when the registered result is ready for writeback.

## Interface
- DATA_WIDTH, 32, operand/result width (fixed at 32 for RV32)
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  synchronous active-low reset
- start_i  input  1  request; accepted only in IDLE or DONE
- md_op_i  input  3  operation, funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operand1_i  input  DATA_WIDTH  rs1 value, sampled only on an accepted start
- operand2_i  input  DATA_WIDTH  rs2 value, sampled only on an accepted start
- flush_i  input  1  abort the in-flight operation (branch mispredict/trap)
- busy_o  output  1  high while in CALC or FIX
- done_o  output  1  one-cycle pulse; result_o valid
- result_o  output  DATA_WIDTH  registered result, held until the next done_o

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1:
  - Latch the op, the operand absolute values and the sign flags.
  - Clear the accumulator and set the 6-bit iteration counter to 0.
  - Go to CALC, or go straight to FIX on a division special case.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - DIV/REM: both operands signed.
  - All other ops: unsigned.
  - Signed operands are converted to magnitude at latch time.
- Multiply: shift-add over a 64-bit product, one multiplier bit per CALC cycle.
- Divide: restoring division, one quotient bit per CALC cycle, with a 33-bit partial remainder subtract.
- CALC lasts exactly 32 cycles; the counter reaching 31 moves the FSM to FIX.
- FIX:
  - Apply sign correction: the product is negated if the sign flags differ; the quotient is negated if the signs differ; the remainder takes the dividend's sign.
  - Select the result: MUL takes the low 32 bits, MULH/MULHSU/MULHU take the high 32 bits, DIV/DIVU take the quotient, REM/REMU take the remainder.
  - Register result_o, then go to DONE.
- DONE: done_o=1 for this single cycle, then go to IDLE unless a new start is accepted.
- Division special cases, detected at start, skip CALC:
  - Divisor 0: quotient = 0xFFFF_FFFF (DIV and DIVU); remainder = dividend (REM and REMU).
  - Signed overflow (DIV/REM with rs1=0x8000_0000 and rs2=0xFFFF_FFFF): DIV gives 0x8000_0000, REM gives 0.
- flush_i has the highest priority in any state:
  - The next state is IDLE and done_o is not asserted.
  - result_o keeps its previous value.
  - A start_i in the same cycle as flush_i is ignored.
- start_i in CALC or FIX is ignored; the latched operands are not disturbed.
- Changes on operand1_i, operand2_i or md_op_i after acceptance have no effect.
- Reset (rst_n_i=0 at an edge) overrides everything, including mid-operation:
  - state = IDLE, busy_o = 0, done_o = 0, result_o = 0, counter = 0.

## Timing
- Start accepted at edge T.
- Normal ops:
  - CALC during cycles T+1..T+32.
  - FIX during T+33.
  - done_o=1 and result_o valid during T+34.
  - Latency is 34 cycles.
- Special-case division: FIX during T+1, done_o during T+2.
- busy_o is high exactly during the CALC and FIX cycles and low in IDLE and DONE.
- Back-to-back: a start in the DONE cycle is accepted; the next done_o follows 34 cycles after that edge.
- done_o never stays high for two consecutive cycles.

## Test plan
- Reset mid-CALC (cycle T+10): busy_o=0, done_o=0 and result_o=0 on the next cycle; no done_o follows.
- MUL 0xFFFF_FFFF×0xFFFF_FFFF:
  - MUL gives 0x0000_0001.
  - MULHU gives 0xFFFF_FFFE.
  - MULH gives 0x0000_0000.
  - MULHSU with rs1=0xFFFF_FFFF, rs2=2 gives 0xFFFF_FFFF.
  - Each done_o arrives exactly 34 cycles after start.
- DIV -7/2 gives 0xFFFF_FFFD and REM -7/2 gives 0xFFFF_FFFF; DIVU 100/7 gives 14 and REMU gives 2.
- Divide by zero, each with done_o at T+2:
  - DIVU 5/0 gives 0xFFFF_FFFF.
  - REM 5/0 gives 5.
- Signed overflow: DIV 0x8000_0000/0xFFFF_FFFF gives 0x8000_0000 and REM gives 0, each with done_o at T+2.
- Handshake:
  - start_i pulsed at T+5 during CALC is ignored and the result is unchanged.
  - flush_i at T+20 gives IDLE with no done_o and result_o holding its old value.
  - Back-to-back start in the DONE cycle produces a second correct done_o 34 cycles later.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and a registered result.
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | 32 iterations of shift-add or restoring divide
// FIX   | sign correction and result select, result_o written
// DONE  | done_o pulse, a new start is accepted here
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [2:0]            md_op_i,
    input  logic [DATA_WIDTH-1:0] operand1_i,
    input  logic [DATA_WIDTH-1:0] operand2_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int W = DATA_WIDTH;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t         state;
    logic [2:0]     op_q;
    logic [W-1:0]   opnd_q;
    logic [2*W-1:0] acc_q;
    logic           neg_res_q;
    logic           neg_rem_q;
    logic           special_q;
    logic [W-1:0]   special_res_q;
    logic [5:0]     count_q;

    logic           is_div;
    logic           sign1;
    logic           sign2;
    logic [W-1:0]   abs1;
    logic [W-1:0]   abs2;
    logic           div_zero;
    logic           div_ovf;
    logic [W-1:0]   special_res;
    logic           accept;

    always_comb begin
        is_div   = md_op_i[2];
        sign1    = operand1_i[W-1] & ((md_op_i == OP_MULH) | (md_op_i == OP_MULHSU) |
                                      (md_op_i == OP_DIV)  | (md_op_i == OP_REM));
        sign2    = operand2_i[W-1] & ((md_op_i == OP_MULH) | (md_op_i == OP_DIV) |
                                      (md_op_i == OP_REM));
        abs1     = sign1 ? -operand1_i : operand1_i;
        abs2     = sign2 ? -operand2_i : operand2_i;
        div_zero = is_div && (operand2_i == '0);
        div_ovf  = is_div && !md_op_i[0] && (operand1_i == {1'b1, {(W-1){1'b0}}}) &&
                   (operand2_i == '1);
        if (div_zero)
            special_res = md_op_i[1] ? operand1_i : '1;
        else
            special_res = md_op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
        accept   = start_i && ((state == S_IDLE) || (state == S_DONE));
    end

    // Multiply: high half accumulates, multiplier bits shift out of the low half.
    // Divide: remainder in the high half, dividend shifts out / quotient shifts in below.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift;
    logic [W:0]     div_diff;
    logic [2*W-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[W])
            div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
        else
            div_next = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    end

    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   fix_res;

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        if (special_q)
            fix_res = special_res_q;
        else if (op_q == OP_MUL)
            fix_res = prod_fix[W-1:0];
        else if (!op_q[2])
            fix_res = prod_fix[2*W-1:W];
        else if (!op_q[1])
            fix_res = quo_fix;
        else
            fix_res = rem_fix;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= S_IDLE;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            result_o      <= '0;
            count_q       <= '0;
            op_q          <= '0;
            opnd_q        <= '0;
            acc_q         <= '0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= '0;
        end else if (flush_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done_o <= 1'b0;
                    if (accept) begin
                        op_q          <= md_op_i;
                        opnd_q        <= is_div ? abs2 : abs1;
                        acc_q         <= {{W{1'b0}}, (is_div ? abs1 : abs2)};
                        neg_res_q     <= sign1 ^ sign2;
                        neg_rem_q     <= sign1;
                        special_q     <= div_zero | div_ovf;
                        special_res_q <= special_res;
                        count_q       <= '0;
                        busy_o        <= 1'b1;
                        state         <= (div_zero | div_ovf) ? S_FIX : S_CALC;
                    end else begin
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_q <= op_q[2] ? div_next : mul_next;
                    if (count_q == 6'd31)
                        state <= S_FIX;
                    else
                        count_q <= count_q + 6'd1;
                end
                S_FIX: begin
                    result_o <= fix_res;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b1;
                    state    <= S_DONE;
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a driver pushes expected results from an
// arithmetic reference model, a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .md_op_i    (md_op),
        .operand1_i (op1),
        .operand2_i (op2),
        .flush_i    (flush),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int unsigned due;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   errors = 0;
    bit   rst_check = 0;

    function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] sa;
        logic [63:0] sbx;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        logic        ovf;
        sa  = {{32{a[31]}}, a};
        sbx = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sbx; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned lat_of(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Call just after a negedge with the unit in IDLE or DONE. Done is due in the
    // cycle ending at edge T+lat, i.e. sampled while cyc == T+lat-1.
    task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        md_op = op;
        op1   = a;
        op2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{ref_model(op, a, b), cyc + lat_of(op, a, b) - 1});
        start = 1'b0;
        md_op = 3'($urandom);
        op1   = $urandom;
        op2   = $urandom;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                check("busy_in_done", {31'b0, busy}, 32'd0);
                return;
            end
        end
        errors++;
        $display("FAIL done_timeout: no done pulse within 200 cycles (cycle %0d)", cyc);
    endtask

    task automatic run_op(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        issue(op, a, b);
        wait_done();
    endtask

    initial begin : monitor
        logic [31:0] last_res;
        bit          prev_done;
        exp_t        e;
        last_res  = '0;
        prev_done = 1'b0;
        wait (rst_n === 1'b1);
        forever begin
            @(negedge clk);
            if (rst_check) begin
                rst_check = 0;
                check("reset_busy", {31'b0, busy}, 32'd0);
                check("reset_done", {31'b0, done}, 32'd0);
                check("reset_result", result, 32'd0);
                last_res = '0;
            end else if (done) begin
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high two cycles in a row (cycle %0d)", cyc);
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done: done with no pending op, result %h (cycle %0d)",
                             result, cyc);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("latency", cyc, e.due);
                    last_res = e.res;
                end
            end else begin
                check("result_hold", result, last_res);
            end
            prev_done = done;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        md_op = '0;
        op1   = '0;
        op2   = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("init_busy", {31'b0, busy}, 32'd0);
        check("init_done", {31'b0, done}, 32'd0);
        check("init_result", result, 32'd0);

        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // start during CALC must not disturb the running multiply
        @(negedge clk);
        issue(3'd0, 32'd123457, 32'd98765);
        repeat (4) @(negedge clk);
        start = 1'b1;
        md_op = 3'd5;
        op1   = 32'd5;
        op2   = 32'd0;
        @(posedge clk);
        #1 start = 1'b0;
        check("ignored_start_busy", {31'b0, busy}, 32'd1);
        wait_done();

        // flush mid-CALC with a same-cycle start: both must be dropped
        @(negedge clk);
        issue(3'd1, 32'h8765_4321, 32'h1234_5678);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        md_op = 3'd5;
        op2   = 32'd0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        sb.delete();
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_done", {31'b0, done}, 32'd0);
        repeat (40) @(negedge clk);

        // back-to-back: second start lands in the DONE cycle
        run_op(3'd4, 32'hFFFF_FF9C, 32'd7);
        issue(3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        wait_done();
        issue(3'd6, 32'd5, 32'd0);
        wait_done();

        // synchronous reset mid-CALC
        @(negedge clk);
        issue(3'd0, 32'd77, 32'd88);
        repeat (9) @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb.delete();
        rst_check = 1;
        repeat (40) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(1, 20));
            else if (sel == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(op, a, b);
            wait_done();
        end

        repeat (5) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: %0d expected results never arrived", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, errors);
        $finish;
    end

endmodule
